led_mode_ctrl: RTL and testbench
================================

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter LED_W, default 8, number of LED outputs (>= 2).
REQ-002 Parameter PB_W, default 7, number of push-button inputs (1 <= PB_W <= LED_W).
REQ-003 Parameter CLKDIV, default 100000000, clock cycles per animation tick (>= 2).
REQ-004 Parameter DB_CYCLES, default 1000000, cycles the start input must stay stable before it is accepted (>= 1).
REQ-005 clk  input  1  system clock; one clock domain only.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mode  input  2  0 pass-through, 1 counter, 2 rotate, 3 bounce.
REQ-008 invert  input  1  complement the LED pattern.
REQ-009 pb  input  PB_W  push buttons, asynchronous to clk.
REQ-010 start  input  1  run/pause push button, asynchronous to clk, bouncy.
REQ-011 cntup  input  1  direction: 1 up/left, 0 down/right.
REQ-012 led  output  LED_W  registered LED drive.
REQ-013 tick  output  1  one-cycle pulse at the divider rollover.
REQ-014 running  output  1  current run flag.

Function
REQ-015 mode, invert, pb, start and cntup SHALL each pass through a 2-flop synchronizer before use.
REQ-016 The divider SHALL count 0..CLKDIV-1 and wrap, assert tick exactly in the cycle count = CLKDIV-1, and run in every mode.
REQ-017 The tick period SHALL be exactly CLKDIV cycles.
REQ-018 The debounced start SHALL change only after the synchronized start holds a new value for DB_CYCLES consecutive cycles; any change restarts the count.
REQ-019 Each rising edge of the debounced start SHALL toggle running; a falling edge has no effect.
REQ-020 Mode 0 SHALL show led[PB_W-1:0] = pb_sync and led[LED_W-1:PB_W] = pb_sync[PB_W-1] replicated, independent of running and tick.
REQ-021 Mode 1 SHALL use an LED_W-bit counter that, on tick with running=1, adds 1 (cntup=1) or subtracts 1 (cntup=0), wrapping modulo 2^LED_W.
REQ-022 Mode 2 SHALL use an LED_W-bit rotate register that, on tick with running=1, rotates left (cntup=1) or right (cntup=0) by one bit.
REQ-023 Mode 3 SHALL use a position 0..LED_W-1 and a direction flag; LED = one-hot(position).
REQ-024 In mode 3, on tick with running=1, position SHALL move one step in its direction; at LED_W-1 moving left, it SHALL go to LED_W-2 and set direction right; at 0 moving right, it SHALL go to 1 and set direction left; cntup is ignored.
REQ-025 Only the register of the currently selected mode SHALL advance; the other registers hold their values across mode changes.
REQ-026 The output SHALL be led = (invert_sync ? ~pattern : pattern), registered once, so a change on pb reaches led 3 cycles later.
REQ-027 A tick in the same cycle as a mode change SHALL advance only the register of the newly synchronized mode.
REQ-028 Ticks with running=0, or in mode 0, SHALL be ignored.

Reset
REQ-029 While rst=1, all registers SHALL clear: divider 0, synchronizers 0, debounce state 0, running 0, counter 0, rotate register 1, position 0, direction left, tick 0, led 0.
REQ-030 Assertion of rst mid-operation SHALL take effect without a clock edge.
REQ-031 After rst is released, the first tick SHALL occur CLKDIV cycles later.

Structure
REQ-032 Package led_ctrl_pkg SHALL hold the mode encodings (MODE_PASS, MODE_COUNT, MODE_ROTATE, MODE_BOUNCE) and the direction constants.
REQ-033 The debouncer SHALL be one sub-module, debounce, parametrised by DB_CYCLES; all other logic sits in led_mode_ctrl.

Verification (LED_W=8, PB_W=7, CLKDIV=4, DB_CYCLES=3)
REQ-034 Test 1: mode=0, invert=0, pb=7'h41 -> led=8'hC1 three cycles later. Then set invert=1 -> led=8'h3E.
REQ-035 Test 2: mode=1, cntup=0, start pressed for 5 cycles -> running=1. The next tick makes led=8'hFF (wrap), and the tick after that makes led=8'hFE.
REQ-036 Test 3: start glitches high for 2 cycles, several times -> running stays 0. Start held for 3 or more cycles, then released, then held again -> running goes 1, then 0.
REQ-037 Test 4: mode=3 while running -> led steps 01,02,...,80,40,...,01,02. Each step lands 4 cycles apart, aligned with tick.
REQ-038 Test 5: mode=2, cntup=1, two ticks -> led=04. Switch to mode 1 for 3 ticks, then back to mode 2 -> led still 04, next tick 08.
REQ-039 Test 6: assert rst asynchronously mid-count -> led=0 and running=0 immediately. After release, tick first pulses 4 cycles later.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED animation controller: display modes, bounce
// direction and the synchronized control bundle.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [1:0] mode;
    logic       invert;
    logic       cntup;
    logic       start;
  } ctl_t;

endpackage

// File: rtl/led_mode_ctrl_debounce.sv
// Start-button debouncer: the accepted level follows din only after din has differed
// from it for DB_CYCLES consecutive cycles; rise pulses the cycle after each 0->1 acceptance.
module debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int            CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          level;
  logic [CW-1:0] cnt;

  // Returning to the accepted level at any point restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= din;
        cnt   <= '0;
        rise  <= din;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED animation controller: pass-through, counter, rotate and bounce patterns stepped
// by a free-running tick divider; led is registered from the post-tick register values.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int PB_W      = 7,
  parameter int CLKDIV    = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             invert,
  input  logic [PB_W-1:0]  pb,
  input  logic             start,
  input  logic             cntup,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             running
);

  localparam int DW = $clog2(CLKDIV);
  localparam int PW = $clog2(LED_W);
  localparam int SW = $bits(ctl_t) + PB_W;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLKDIV - 2);
  localparam logic [PW-1:0] POS_TOP  = PW'(LED_W - 1);
  localparam logic [PW-1:0] POS_TURN = PW'(LED_W - 2);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);

  logic [SW-1:0]    sync1, sync2;
  ctl_t             ctl_s;
  logic [PB_W-1:0]  pb_s;

  logic [DW-1:0]    div;
  logic             start_rise;
  logic             adv;

  logic [LED_W-1:0] cnt, cnt_nxt;
  logic [LED_W-1:0] rot, rot_nxt;
  logic [PW-1:0]    pos, pos_nxt;
  logic             dir, dir_nxt;
  logic [LED_W-1:0] pat;

  // Every asynchronous input shares one two-stage synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode, invert, cntup, start, pb};
      sync2 <= sync1;
    end
  end

  assign {ctl_s, pb_s} = sync2;

  // tick is registered but still coincides with the cycle in which div == CLKDIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= (div == DIV_LAST) ? '0 : div + 1'b1;
      tick <= (div == DIV_PRE);
    end
  end

  debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (ctl_s.start),
    .rise(start_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
    end else if (start_rise) begin
      running <= ~running;
    end
  end

  assign adv = tick & running;

  // Only the register owned by the currently synchronized mode steps on a tick.
  always_comb begin
    cnt_nxt = cnt;
    rot_nxt = rot;
    pos_nxt = pos;
    dir_nxt = dir;
    if (adv) begin
      case (ctl_s.mode)
        MODE_COUNT: begin
          cnt_nxt = ctl_s.cntup ? cnt + 1'b1 : cnt - 1'b1;
        end
        MODE_ROTATE: begin
          rot_nxt = ctl_s.cntup ? {rot[LED_W-2:0], rot[LED_W-1]}
                                : {rot[0], rot[LED_W-1:1]};
        end
        MODE_BOUNCE: begin
          if (dir == DIR_LEFT) begin
            if (pos == POS_TOP) begin
              pos_nxt = POS_TURN;
              dir_nxt = DIR_RIGHT;
            end else begin
              pos_nxt = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              pos_nxt = POS_ONE;
              dir_nxt = DIR_LEFT;
            end else begin
              pos_nxt = pos - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rot <= {{(LED_W-1){1'b0}}, 1'b1};
      pos <= '0;
      dir <= DIR_LEFT;
    end else begin
      cnt <= cnt_nxt;
      rot <= rot_nxt;
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

  // Pattern uses the next-state values so led moves on the same edge as the tick.
  always_comb begin
    pat = '0;
    case (ctl_s.mode)
      MODE_PASS: begin
        for (int i = 0; i < PB_W; i++) begin
          pat[i] = pb_s[i];
        end
        for (int i = PB_W; i < LED_W; i++) begin
          pat[i] = pb_s[PB_W-1];
        end
      end
      MODE_COUNT:  pat = cnt_nxt;
      MODE_ROTATE: pat = rot_nxt;
      MODE_BOUNCE: pat = {{(LED_W-1){1'b0}}, 1'b1} << pos_nxt;
      default:     pat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= ctl_s.invert ? ~pat : pat;
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed and randomized checks of led_mode_ctrl against a cycle-level behavioural model
// built from phase/rotation counters, a start-history window and a two-deep input delay.
module tb_led_mode_ctrl;

  localparam int LED_W  = 8;
  localparam int PB_W   = 7;
  localparam int CLKDIV = 4;
  localparam int DB     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             invert;
  logic [PB_W-1:0]  pb;
  logic             start;
  logic             cntup;
  logic [LED_W-1:0] led;
  logic             tick;
  logic             running;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .LED_W(LED_W), .PB_W(PB_W), .CLKDIV(CLKDIV), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .invert(invert), .pb(pb),
    .start(start), .cntup(cntup), .led(led), .tick(tick), .running(running)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic            invert;
    logic [PB_W-1:0] pb;
    logic            start;
    logic            cntup;
  } in_t;

  // Model state: inputs seen through two cycles of delay, history of synced start,
  // counter value, rotation amount and bounce phase (0..2*(LED_W-1)-1).
  in_t              s1, s2;
  bit               st_hist[$];
  bit               db_m, rise_m, run_m;
  int               edges, cnt_m, rot_m, ph_m;
  logic [LED_W-1:0] led_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LED_W-1:0] pattern(input in_t s);
    logic [LED_W-1:0] p;
    int pos;
    case (s.mode)
      2'd0:    p = {s.pb[PB_W-1], s.pb};
      2'd1:    p = cnt_m[LED_W-1:0];
      2'd2:    p = 8'h01 << rot_m;
      default: begin
        pos = (ph_m < LED_W) ? ph_m : 2 * (LED_W - 1) - ph_m;
        p   = 8'h01 << pos;
      end
    endcase
    return s.invert ? ~p : p;
  endfunction

  task automatic model_reset();
    s1 = '0; s2 = '0;
    st_hist.delete();
    db_m = 0; rise_m = 0; run_m = 0;
    edges = 0; cnt_m = 0; rot_m = 0; ph_m = 0;
    led_m = '0;
  endtask

  task automatic model_edge(input in_t cur);
    bit tick_c, adv, all_diff, new_rise;
    tick_c = (edges % CLKDIV) == CLKDIV - 1;
    adv    = tick_c && run_m;
    st_hist.push_back(s2.start);
    if (st_hist.size() > DB) void'(st_hist.pop_front());
    all_diff = (st_hist.size() == DB);
    foreach (st_hist[i]) if (st_hist[i] == db_m) all_diff = 0;
    new_rise = 0;
    if (all_diff) begin
      db_m     = !db_m;
      new_rise = db_m;
    end
    if (rise_m) run_m = !run_m;
    rise_m = new_rise;
    if (adv) begin
      case (s2.mode)
        2'd1:    cnt_m = s2.cntup ? (cnt_m + 1) % 256 : (cnt_m + 255) % 256;
        2'd2:    rot_m = s2.cntup ? (rot_m + 1) % LED_W : (rot_m + LED_W - 1) % LED_W;
        2'd3:    ph_m  = (ph_m + 1) % (2 * (LED_W - 1));
        default: ;
      endcase
    end
    led_m = pattern(s2);
    s2 = s1;
    s1 = cur;
    edges++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge({mode, invert, pb, start, cntup});
      #1;
      chk("led", led, led_m);
      chk("running", running, run_m);
      chk("tick", tick, ((edges % CLKDIV) == CLKDIV - 1));
    end
  endtask

  task automatic wait_running(input logic want, input string tag);
    int b = 0;
    while (running !== want && b < 30) begin
      step(1);
      b++;
    end
    chk(tag, running, want);
  endtask

  task automatic wait_tick();
    int b = 0;
    while (tick !== 1'b1 && b < 3 * CLKDIV) begin
      step(1);
      b++;
    end
    chk("tick_seen", tick, 1);
  endtask

  logic [LED_W-1:0] bexp[15];

  initial begin
    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    rst = 1'b1; mode = 2'd0; invert = 1'b0; pb = '0; start = 1'b0; cntup = 1'b1;
    model_reset();
    #12;
    chk("reset_led", led, 0);
    chk("reset_running", running, 0);
    chk("reset_tick", tick, 0);
    #6 rst = 1'b0;

    // Pass-through latency and inversion
    pb = 7'h41;
    step(2);
    chk("pass_not_yet", led, 8'h00);
    step(1);
    chk("pass_c1", led, 8'hC1);
    invert = 1'b1;
    step(3);
    chk("pass_inv_3e", led, 8'h3E);
    invert = 1'b0;
    step(3);

    // Short start glitches never qualify
    for (int g = 0; g < 5; g++) begin
      start = 1'b1;
      step($urandom_range(1, 2));
      start = 1'b0;
      step($urandom_range(1, 4));
    end
    step(6);
    chk("glitch_running", running, 0);
    start = 1'b1;
    step(4);
    start = 1'b0;
    wait_running(1'b1, "press_on");
    step(8);
    chk("release_no_effect", running, 1);
    start = 1'b1;
    step(4);
    start = 1'b0;
    wait_running(1'b0, "press_off");

    // Counter down with wrap
    mode = 2'd1; cntup = 1'b0;
    step(4);
    chk("count_idle", led, 8'h00);
    start = 1'b1;
    step(5);
    start = 1'b0;
    wait_running(1'b1, "count_run");
    wait_tick();
    step(1);
    chk("count_ff", led, 8'hFF);
    wait_tick();
    step(1);
    chk("count_fe", led, 8'hFE);

    // Bounce, one step per tick, starting from position 0
    mode = 2'd3; cntup = 1'($urandom_range(0, 1));
    step(3);
    chk("bounce_start", led, 8'h01);
    chk("bounce_tick_aligned", tick, 1);
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("bounce_step", led, bexp[i]);
      step(3);
      chk("bounce_hold", led, bexp[i]);
      chk("bounce_tick", tick, 1);
    end
    step(1);

    // Rotate left, park in counter mode, resume rotate
    mode = 2'd2; cntup = 1'b1;
    step(3);
    chk("rot_start", led, 8'h01);
    step(1);
    chk("rot_02", led, 8'h02);
    step(3);
    step(1);
    chk("rot_04", led, 8'h04);
    mode = 2'd1;
    step(3);
    step(1);
    step(4);
    step(4);
    mode = 2'd2;
    step(3);
    chk("rot_held_04", led, 8'h04);
    step(1);
    chk("rot_08", led, 8'h08);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0) invert = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cntup = 1'($urandom_range(0, 1));
      pb = 7'($urandom);
      step(1);
    end

    // Asynchronous reset mid-count
    start = 1'b0; mode = 2'd1; invert = 1'b1;
    step(8);
    #3 rst = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_running", running, 0);
    chk("arst_tick", tick, 0);
    @(posedge clk);
    #1;
    chk("arst_hold_led", led, 0);
    #2 rst = 1'b0;
    model_reset();
    // The release cycle is the first of the CLKDIV cycles, so tick shows after CLKDIV-1 edges.
    begin
      int n = 0;
      while (tick !== 1'b1 && n < 3 * CLKDIV) begin
        step(1);
        n++;
      end
      chk("first_tick_edges", n, CLKDIV - 1);
    end
    step(CLKDIV);
    chk("tick_period", tick, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
